// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin arbiter sequencing writes into a shared bank of level-sensitive latches
// Each write runs as setup, open and hold phases, so latch_d is stable before, during and after the enable window.
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   req, wdata    per-requester write request and flattened data (requester i at [i*WIDTH +: WIDTH])
//   gnt, ack      one-hot grant held for the transaction, one-cycle completion pulse
//   latch_d       data driven to the latch bank
//   latch_en      enable driven to the latch bank
//   busy          high whenever a transaction is in flight
module latch_bank_arbiter #(
  parameter int WIDTH       = 8,
  parameter int N_REQ       = 4,
  parameter int OPEN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       latch_d,
  output logic                   latch_en,
  output logic                   busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(OPEN_CYCLES + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] OPEN  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;
  if (N_REQ < 2 || N_REQ > 8 || OPEN_CYCLES < 1) begin : g_bad_params
    $error("latch_bank_arbiter: N_REQ must be 2..8 and OPEN_CYCLES at least 1");
  end
  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, win_q, win_d, win;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             en_q, en_d, busy_q, busy_d;
  int               win_i, idx;
  // Walk from the lowest priority slot up so the last hit is the one nearest ptr.
  always_comb begin
    win_i = 0;
    idx = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (req[idx]) win_i = idx;
    end
    win = PW'(win_i);
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    data_d  = data_q;
    en_d    = en_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = SETUP;
        win_d   = win;
        gnt_d   = N_REQ'(1) << win;
        data_d  = wdata[win_i*WIDTH +: WIDTH];
      end
      SETUP: begin
        state_d = OPEN;
        en_d    = 1'b1;
        cnt_d   = '0;
      end
      OPEN: if (cnt_q == CW'(OPEN_CYCLES - 1)) begin
        state_d = HOLD;
        en_d    = 1'b0;
        ack_d   = gnt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        ack_d   = '0;
        gnt_d   = '0;
        ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end
  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign latch_d  = data_q;
  assign latch_en = en_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb_latch_bank_arbiter: directed and randomized checks of latch_bank_arbiter against a transaction-level model
module tb_latch_bank_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int OC = 2;
  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   latch_d;
  logic           latch_en, busy;
  int checks = 0;
  int passes = 0;
  latch_bank_arbiter #(.WIDTH(W), .N_REQ(N), .OPEN_CYCLES(OC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .latch_d(latch_d), .latch_en(latch_en), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [W-1:0] q_lat;
  always_latch if (latch_en) q_lat <= latch_d;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  // Transaction model: t counts edges since the grant; a write spans t=0..OC+1, then one idle edge.
  bit           m_act;
  int           m_t, m_ptr, m_win;
  logic [W-1:0] m_data;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_t = 0; m_ptr = 0; m_win = 0; m_data = '0;
    end else if (m_act) begin
      m_t++;
      if (m_t == OC + 2) begin
        m_act = 0;
        m_ptr = (m_win + 1) % N;
      end
    end else if (req != '0) begin
      for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) begin
        m_win = (m_ptr + k) % N;
        break;
      end
      m_act = 1; m_t = 0;
      m_data = wdata[m_win*W +: W];
    end
  end
  logic [N-1:0] e_gnt, e_ack;
  logic         e_en;
  logic [W-1:0] prev_d;
  logic         prev_en = 1'b0;
  always @(negedge clk) begin
    e_gnt = m_act ? N'(1) << m_win : '0;
    e_en  = m_act && m_t >= 1 && m_t <= OC;
    e_ack = (m_act && m_t == OC + 1) ? e_gnt : '0;
    chk("gnt", gnt, e_gnt);
    chk("ack", ack, e_ack);
    chk("latch_en", latch_en, e_en);
    chk("busy", busy, m_act);
    chk("latch_d", latch_d, m_data);
    if (prev_en && latch_en) chk("latch_d_stable_open", latch_d, prev_d);
    if (ack != '0) chk("latch_q_after_ack", q_lat, latch_d);
    prev_d  = latch_d;
    prev_en = latch_en;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      req   = N'($urandom_range(0, 15));
      wdata = {$urandom, $urandom};
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_en", latch_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_latch_d", latch_d, 8'h00);
    end
    req = 4'b1010;
    wdata[1*W +: W] = 8'hA5;
    wdata[3*W +: W] = 8'h77;
    rst_n = 1'b1;
    tick();
    chk("t1_first_gnt", gnt, 4'b0010);
    chk("t2_d_setup", latch_d, 8'hA5);
    chk("t2_en_setup", latch_en, 1'b0);
    req = 4'b0000;
    tick();
    chk("t2_en_open1", latch_en, 1'b1);
    tick();
    chk("t2_en_open2", latch_en, 1'b1);
    tick();
    chk("t2_en_hold", latch_en, 1'b0);
    chk("t2_ack", ack, 4'b0010);
    chk("t2_d_hold", latch_d, 8'hA5);
    chk("t2_q", q_lat, 8'hA5);
    req = 4'b0010;
    tick();
    chk("t2_idle_gnt", gnt, 4'b0000);
    chk("t2_idle_ack", ack, 4'b0000);
    tick();
    chk("t2_next_gnt", gnt, 4'b0010);
    req = 4'b0000;
    ticks(4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_gnt", gnt, N'(1) << (k % N));
      if (k == 4) req = 4'b0000;
      ticks(3);
      chk("t3_ack", ack, N'(1) << (k % N));
      tick();
    end
    req = 4'b0100;
    tick();
    chk("t4_serve2", gnt, 4'b0100);
    req = 4'b0000;
    ticks(4);
    req = 4'b1001;
    tick();
    chk("t4_gnt3", gnt, 4'b1000);
    ticks(4);
    tick();
    chk("t4_gnt0", gnt, 4'b0001);
    req = 4'b0000;
    ticks(4);
    wdata[0*W +: W] = 8'h3C;
    req = 4'b0001;
    tick();
    chk("t5_d_grant", latch_d, 8'h3C);
    req = 4'b0000;
    tick();
    wdata[0*W +: W] = 8'hFF;
    tick();
    chk("t5_d_open", latch_d, 8'h3C);
    tick();
    chk("t5_d_hold", latch_d, 8'h3C);
    tick();
    req = 4'b0001;
    tick();
    tick();
    chk("t6_en_before_rst", latch_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", latch_en, 1'b0);
    chk("t6_rst_gnt", gnt, 4'b0000);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_ack", ack, 4'b0000);
    req = 4'b0100;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_gnt2", gnt, 4'b0100);
    req = 4'b0000;
    ticks(3);
    chk("t6_ack2", ack, 4'b0100);
    tick();
    for (int c = 0; c < 3000; c++) begin
      tick();
      req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      wdata = {$urandom, $urandom};
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
